// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=7, rate-1/2 (133/171 octal)
// Viterbi add-compare-select datapath.
package viterbi_pkg;

  localparam int unsigned K       = 7;
  localparam int unsigned NSTATES = 64;
  localparam int unsigned SW      = 6;
  localparam logic [K-1:0] G0     = 7'o133;
  localparam logic [K-1:0] G1     = 7'o171;

  // Encoder output {e1,e0} when input bit u is shifted into state
  function automatic logic [1:0] exp_bits(input logic [SW-1:0] state, input logic u);
    logic [K-1:0] r;
    r = {state, u};
    return {^(r & G1), ^(r & G0)};
  endfunction

  // Hamming distance between two bit pairs (0..2)
  function automatic logic [1:0] hamming2(input logic [1:0] rx, input logic [1:0] exp);
    logic [1:0] d;
    d = rx ^ exp;
    return 2'(d[0]) + 2'(d[1]);
  endfunction

endpackage

// File: rtl/viterbi_acs_cell.sv
// One add-compare-select butterfly half: picks the cheaper of two
// predecessor paths into a single next state. Ties go to predecessor p0.
module viterbi_acs_cell
  import viterbi_pkg::*;
#(
  parameter int unsigned MW = 7
) (
  input  logic [MW-1:0] pm0,
  input  logic [MW-1:0] pm1,
  input  logic [1:0]    bm0,
  input  logic [1:0]    bm1,
  output logic [MW-1:0] metric_c,
  output logic          dec_c
);

  logic [MW-1:0] cand0;
  logic [MW-1:0] cand1;

  // Saturating add: once the metric is within 1 of full scale it pins at max
  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] pm, input logic [1:0] bm);
    if (&pm[MW-1:1]) begin
      return '1;
    end
    return pm + MW'(bm);
  endfunction

  // Add both candidates, then select the smaller (p0 on ties)
  always_comb begin
    cand0    = sat_add(pm0, bm0);
    cand1    = sat_add(pm1, bm1);
    metric_c = cand0;
    dec_c    = 1'b0;
    if (cand1 < cand0) begin
      metric_c = cand1;
      dec_c    = 1'b1;
    end
  end

endmodule

// File: rtl/viterbi_acs_bank.sv
// 64-state ACS bank for the 802.11a Viterbi decoder. Holds the registered
// path metrics, runs one trellis step per valid input pair, normalises, and
// registers survivor decisions plus the best state/metric.
// Optional build macro: VITERBI_ERASURE_EN adds rx_erase[1:0]; erased bits
// do not contribute to the branch metric.
module viterbi_acs_bank
  import viterbi_pkg::*;
#(
  parameter int unsigned MW        = 7,
  parameter int unsigned INIT_BIAS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [1:0]         rx_bits,
`ifdef VITERBI_ERASURE_EN
  input  logic [1:0]         rx_erase,
`endif
  output logic               dec_valid,
  output logic [NSTATES-1:0] dec,
  output logic [SW-1:0]      best_state,
  output logic [MW-1:0]      best_metric
);

  localparam logic [MW-1:0] BIAS = MW'(INIT_BIAS);

  logic [MW-1:0]      metric_q   [NSTATES];
  logic [MW-1:0]      src_metric [NSTATES];
  logic [MW-1:0]      sel_metric [NSTATES];
  logic [MW-1:0]      new_metric [NSTATES];
  logic [NSTATES-1:0] dec_c;
  logic [1:0]         erase;
  logic [1:0]         bm_tab     [4];
  logic [SW-1:0]      best_state_c;
  logic [MW-1:0]      best_metric_c;

  function automatic logic [MW-1:0] init_metric(input int unsigned idx);
    return (idx == 0) ? '0 : BIAS;
  endfunction

`ifdef VITERBI_ERASURE_EN
  assign erase = rx_erase;
`else
  assign erase = 2'b00;
`endif

  // Branch metric for each of the four possible expected pairs; an erased bit
  // is compared against itself so it never counts as a mismatch
  always_comb begin
    for (int e = 0; e < 4; e++) begin
      bm_tab[e] = hamming2(rx_bits, (2'(e) & ~erase) | (rx_bits & erase));
    end
  end

  // A step issued together with start works from the initial metrics
  always_comb begin
    for (int i = 0; i < NSTATES; i++) begin
      src_metric[i] = start ? init_metric(i) : metric_q[i];
    end
  end

  // One ACS cell per next state; predecessors and expected pairs are fixed by the trellis
  for (genvar g = 0; g < NSTATES; g++) begin : g_acs
    localparam logic [SW-1:0] NS = SW'(g);
    localparam logic [SW-1:0] P0 = {1'b0, NS[SW-1:1]};
    localparam logic [SW-1:0] P1 = {1'b1, NS[SW-1:1]};
    localparam logic [1:0]    E0 = exp_bits(P0, NS[0]);
    localparam logic [1:0]    E1 = exp_bits(P1, NS[0]);

    viterbi_acs_cell #(
      .MW (MW)
    ) u_cell (
      .pm0      (src_metric[P0]),
      .pm1      (src_metric[P1]),
      .bm0      (bm_tab[E0]),
      .bm1      (bm_tab[E1]),
      .metric_c (sel_metric[g]),
      .dec_c    (dec_c[g])
    );
  end

  // Drop half of full scale from every metric once all of them are in the upper half
  always_comb begin
    logic all_msb;
    all_msb = 1'b1;
    for (int i = 0; i < NSTATES; i++) begin
      all_msb = all_msb & sel_metric[i][MW-1];
    end
    for (int i = 0; i < NSTATES; i++) begin
      new_metric[i] = all_msb ? {1'b0, sel_metric[i][MW-2:0]} : sel_metric[i];
    end
  end

  // Balanced argmin tree; the left (lower-index) entry wins ties at every level
  always_comb begin
    logic [MW-1:0] am [NSTATES];
    logic [SW-1:0] ai [NSTATES];
    for (int i = 0; i < NSTATES; i++) begin
      am[i] = new_metric[i];
      ai[i] = SW'(i);
    end
    for (int w = NSTATES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        if (am[2*i+1] < am[2*i]) begin
          am[i] = am[2*i+1];
          ai[i] = ai[2*i+1];
        end else begin
          am[i] = am[2*i];
          ai[i] = ai[2*i];
        end
      end
    end
    best_metric_c = am[0];
    best_state_c  = ai[0];
  end

  // Path metric registers: step on valid, reload on bare start, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSTATES; i++) begin
        metric_q[i] <= init_metric(i);
      end
    end else if (in_valid) begin
      for (int i = 0; i < NSTATES; i++) begin
        metric_q[i] <= new_metric[i];
      end
    end else if (start) begin
      for (int i = 0; i < NSTATES; i++) begin
        metric_q[i] <= init_metric(i);
      end
    end
  end

  // Decision and best-path outputs, refreshed only on a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid   <= 1'b0;
      dec         <= '0;
      best_state  <= '0;
      best_metric <= '0;
    end else begin
      dec_valid <= in_valid;
      if (in_valid) begin
        dec         <= dec_c;
        best_state  <= best_state_c;
        best_metric <= best_metric_c;
      end
    end
  end

endmodule
